// File: rtl/pixel_stream_packer_pkg.sv
// Shared types and constants for the Camera Link pixel packer and its output FIFO.
package pixel_stream_pkg;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        WAIT_FRAME = 2'd1,
        IN_FRAME   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0]       data;
        logic [PIX_PER_WORD-1:0] keep;
        logic                    last;
        logic                    user;
    } fifo_entry_t;

    // Byte enables for a partial word holding n pixels (lanes 0..n-1).
    function automatic logic [PIX_PER_WORD-1:0] keep_mask(input logic [LANE_W-1:0] n);
        logic [PIX_PER_WORD-1:0] m;
        m = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (i < int'(n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pixel_stream_fifo.sv
// First-word-fall-through FIFO with a registered head word; capacity is DEPTH entries
// including the one presented on rd_data.
module pixel_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 38
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             valid_reg;
    logic             pop;
    logic             wr_ok;

    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign empty      = !valid_reg;
    assign pop        = valid_reg && rd_en;
    // A pop on the same edge frees the slot, so a push while full is still accepted.
    assign wr_ok      = wr_en && (!full || pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign rd_data    = rd_data_reg;

    always_ff @(posedge clk_fast) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({wr_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            // Head register: next stored word, or the incoming word when it lands in an empty queue.
            if (pop) begin
                if (count_reg > (AW+1)'(1)) begin
                    rd_data_reg <= mem[rd_ptr_inc];
                    valid_reg   <= 1'b1;
                end else if (wr_ok) begin
                    rd_data_reg <= wr_data;
                    valid_reg   <= 1'b1;
                end else begin
                    valid_reg   <= 1'b0;
                end
            end else if (!valid_reg && wr_ok) begin
                rd_data_reg <= wr_data;
                valid_reg   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs the Camera Link byte-pixel strobe stream into 32-bit AXI4-Stream words.
// Optional per-line length check: define PIXEL_STREAM_PACKER_LINE_CHECK_EN.
module pixel_stream_packer
    import pixel_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int LINE_PIX   = 640
) (
    input  logic                    clk_fast,
    input  logic                    rst_n,
    input  logic [PIX_W-1:0]        pix_data,
    input  logic                    pix_valid,
    input  logic                    pix_fval,
    input  logic                    pix_lval,
    output logic [WORD_W-1:0]       m_axis_tdata,
    output logic [PIX_PER_WORD-1:0] m_axis_tkeep,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        ovf_cnt
`ifdef PIXEL_STREAM_PACKER_LINE_CHECK_EN
    ,
    output logic                    line_len_err
`endif
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

    state_t                  state_reg;
    logic [LANE_W-1:0]       byte_cnt_reg;
    logic [WORD_W-1:0]       word_reg;
    logic [WORD_W-1:0]       hold_reg;
    logic                    hold_valid_reg;
    logic                    hold_final_reg;
    logic [PIX_PER_WORD-1:0] final_keep_reg;
    logic                    sof_reg;
    logic                    line_open_reg;
    logic [CNT_W-1:0]        frame_cnt_reg;
    logic [CNT_W-1:0]        ovf_cnt_reg;

    logic        capture;
    logic        line_end;
    logic        push_en;
    fifo_entry_t push_entry;
    fifo_entry_t fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    assign capture  = pix_valid && pix_fval && pix_lval &&
                      (state_reg == IN_FRAME || state_reg == WAIT_FRAME);
    assign line_end = pix_valid && (state_reg == IN_FRAME) && (!pix_fval || !pix_lval);
    assign fifo_pop = m_axis_tvalid && m_axis_tready;

    always_comb begin
        push_en    = 1'b0;
        push_entry = '0;
        if (hold_final_reg) begin
            // Second half of a split flush: the staged partial word closes the line.
            push_en         = 1'b1;
            push_entry.data = hold_reg;
            push_entry.keep = final_keep_reg;
            push_entry.last = 1'b1;
            push_entry.user = sof_reg;
        end else if (hold_valid_reg && (capture || line_end)) begin
            push_en         = 1'b1;
            push_entry.data = hold_reg;
            push_entry.keep = '1;
            push_entry.last = line_end && (byte_cnt_reg == '0);
            push_entry.user = sof_reg;
        end else if (line_end && (byte_cnt_reg != '0)) begin
            push_en         = 1'b1;
            push_entry.data = word_reg;
            push_entry.keep = keep_mask(byte_cnt_reg);
            push_entry.last = 1'b1;
            push_entry.user = sof_reg;
        end
    end

`ifdef PIXEL_STREAM_PACKER_LINE_CHECK_EN
    logic [CNT_W-1:0] pix_cnt_reg;
    logic             line_err_reg;

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_reg  <= '0;
            line_err_reg <= 1'b0;
        end else if (line_end) begin
            if (line_open_reg && (pix_cnt_reg != CNT_W'(LINE_PIX))) begin
                line_err_reg <= 1'b1;
            end
            pix_cnt_reg <= '0;
        end else if (capture && (pix_cnt_reg != '1)) begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
    end

    assign line_len_err = line_err_reg;
`else
    // LINE_PIX only matters to the line-length check.
    if (LINE_PIX < 0) begin : g_line_pix_unused
    end
`endif

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SYNC;
            byte_cnt_reg   <= '0;
            word_reg       <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            hold_final_reg <= 1'b0;
            final_keep_reg <= '0;
            sof_reg        <= 1'b0;
            line_open_reg  <= 1'b0;
            frame_cnt_reg  <= '0;
            ovf_cnt_reg    <= '0;
        end else begin
            hold_final_reg <= 1'b0;
            if (push_en && push_entry.user) begin
                sof_reg <= 1'b0;
            end
            if (hold_valid_reg && (capture || line_end)) begin
                hold_valid_reg <= 1'b0;
            end

            if (pix_valid) begin
                case (state_reg)
                    SYNC: begin
                        if (!pix_fval) begin
                            state_reg <= WAIT_FRAME;
                        end
                    end
                    WAIT_FRAME: begin
                        if (pix_fval) begin
                            state_reg <= IN_FRAME;
                            sof_reg   <= 1'b1;
                        end
                    end
                    IN_FRAME: begin
                        if (!pix_fval) begin
                            state_reg     <= WAIT_FRAME;
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end
                    end
                    default: state_reg <= SYNC;
                endcase
            end

            if (capture) begin
                line_open_reg <= 1'b1;
                if (byte_cnt_reg == LAST_LANE) begin
                    hold_reg       <= {pix_data, word_reg[WORD_W-PIX_W-1:0]};
                    hold_valid_reg <= 1'b1;
                    word_reg       <= '0;
                    byte_cnt_reg   <= '0;
                end else begin
                    word_reg[byte_cnt_reg*PIX_W +: PIX_W] <= pix_data;
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end

            if (line_end) begin
                // Full hold plus a partial word: hold goes now, partial is staged for the next edge.
                if (hold_valid_reg && (byte_cnt_reg != '0)) begin
                    hold_reg       <= word_reg;
                    final_keep_reg <= keep_mask(byte_cnt_reg);
                    hold_final_reg <= 1'b1;
                end
                word_reg      <= '0;
                byte_cnt_reg  <= '0;
                line_open_reg <= 1'b0;
            end

            if (push_en && fifo_full && !fifo_pop && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end
        end
    end

    pixel_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .wr_en    (push_en),
        .wr_data  (push_entry),
        .rd_en    (m_axis_tready),
        .rd_data  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_axis_tdata  = fifo_dout.data;
    assign m_axis_tkeep  = fifo_dout.keep;
    assign m_axis_tuser  = fifo_dout.user;
    assign m_axis_tlast  = fifo_dout.last;
    assign m_axis_tvalid = !fifo_empty;
    assign frame_cnt     = frame_cnt_reg;
    assign ovf_cnt       = ovf_cnt_reg;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer; line-length cases need PIXEL_STREAM_PACKER_LINE_CHECK_EN.
module tb_pixel_stream_packer;

    logic        clk_fast = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_fval  = 1'b0;
    logic        pix_lval  = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] frame_cnt;
    logic [15:0] ovf_cnt;
`ifdef PIXEL_STREAM_PACKER_LINE_CHECK_EN
    logic        line_len_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Words are {data, keep, user, last}.
    logic [37:0] got_q[$];
    logic [37:0] exp_q[$];
    int          got_rd = 0;
    int          valid_cycles = 0;

    always #5 clk_fast = ~clk_fast;

    pixel_stream_packer #(
        .FIFO_DEPTH (4),
        .CNT_W      (16),
        .LINE_PIX   (8)
    ) dut (
        .clk_fast      (clk_fast),
        .rst_n         (rst_n),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_fval      (pix_fval),
        .pix_lval      (pix_lval),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_cnt     (frame_cnt),
        .ovf_cnt       (ovf_cnt)
`ifdef PIXEL_STREAM_PACKER_LINE_CHECK_EN
        ,
        .line_len_err  (line_len_err)
`endif
    );

    // Inputs change at posedge+1, so the falling edge sees the word that the next rising edge pops.
    always @(negedge clk_fast) begin
        if (m_axis_tvalid) begin
            valid_cycles++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    task automatic beat(input logic fv, input logic lv, input logic [7:0] d);
        pix_fval  = fv;
        pix_lval  = lv;
        pix_data  = d;
        pix_valid = 1'b1;
        tick(1);
        pix_valid = 1'b0;
        tick(3);
    endtask

    // n pixels base, base+1, ... then an lval=0 beat closing the line.
    task automatic send_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            beat(1'b1, 1'b1, base + 8'(i));
        end
        beat(1'b1, 1'b0, 8'h00);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic u, input logic l);
        exp_q.push_back({d, k, u, l});
    endtask

    task automatic drain_check(input string tag);
        int n_got;
        for (int c = 0; c < 200 && (got_q.size() - got_rd) < exp_q.size(); c++) begin
            tick(1);
        end
        tick(4);
        n_got = got_q.size() - got_rd;
        check_val({tag, "_count"}, 64'(n_got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
            check_val($sformatf("%s_w%0d", tag, i), 64'(got_q[got_rd + i]), 64'(exp_q[i]));
        end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_val("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        rst_n = 1'b1;
        tick(2);
        beat(1'b0, 1'b0, 8'h00);

        // 8-pixel line: two full words, the second closes the line.
        send_line(8'h01, 8);
        beat(1'b0, 1'b0, 8'h00);
        expect_word(32'h04030201, 4'hF, 1'b1, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0, 1'b1);
        drain_check("line8");
        check_val("line8_frame_cnt", 64'(frame_cnt), 64'd1);

        // 6-pixel line after two empty lines: partial word with keep 3.
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b1, 1'b0, 8'h00);
        send_line(8'h11, 6);
        beat(1'b0, 1'b0, 8'h00);
        expect_word(32'h14131211, 4'hF, 1'b1, 1'b0);
        expect_word(32'h00001615, 4'h3, 1'b0, 1'b1);
        drain_check("line6");
        check_val("line6_frame_cnt", 64'(frame_cnt), 64'd2);

        // fval falling closes an open 5-pixel line.
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b1, 8'h21 + 8'(i));
        end
        beat(1'b0, 1'b0, 8'h00);
        expect_word(32'h24232221, 4'hF, 1'b1, 1'b0);
        expect_word(32'h00000025, 4'h1, 1'b0, 1'b1);
        drain_check("fvfall");
        check_val("fvfall_frame_cnt", 64'(frame_cnt), 64'd3);

        // Backpressure: 6 words into a 4-deep FIFO, two dropped.
        m_axis_tready = 1'b0;
        send_line(8'h40, 24);
        check_val("bp_ovf_cnt", 64'(ovf_cnt), 64'd2);
        check_val("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_val("bp_head", 64'(m_axis_tdata), 64'h43424140);
        tick(5);
        check_val("bp_head_stable", 64'(m_axis_tdata), 64'h43424140);
        beat(1'b0, 1'b0, 8'h00);
        m_axis_tready = 1'b1;
        expect_word(32'h43424140, 4'hF, 1'b1, 1'b0);
        expect_word(32'h47464544, 4'hF, 1'b0, 1'b0);
        expect_word(32'h4B4A4948, 4'hF, 1'b0, 1'b0);
        expect_word(32'h4F4E4D4C, 4'hF, 1'b0, 1'b0);
        drain_check("bp");
        check_val("bp_frame_cnt", 64'(frame_cnt), 64'd4);

        // Reset in the middle of a line with one word waiting.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b1, 8'h51 + 8'(i));
        end
        check_val("midrst_tvalid_before", 64'(m_axis_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_val("midrst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        tick(2);
        m_axis_tready = 1'b1;
        pix_fval = 1'b1;
        pix_lval = 1'b1;
        rst_n = 1'b1;
        tick(1);

        // Released mid-frame: everything until fval drops is ignored.
        valid_cycles = 0;
        send_line(8'h60, 8);
        send_line(8'h68, 4);
        check_val("sync_no_tvalid", 64'(valid_cycles), 64'd0);
        check_val("sync_frame_cnt", 64'(frame_cnt), 64'd0);
        beat(1'b0, 1'b0, 8'h00);
        send_line(8'h71, 4);
        beat(1'b0, 1'b0, 8'h00);
        expect_word(32'h74737271, 4'hF, 1'b1, 1'b1);
        drain_check("sync");
        check_val("sync_frame_cnt_after", 64'(frame_cnt), 64'd1);

`ifdef PIXEL_STREAM_PACKER_LINE_CHECK_EN
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_val("len_rst", 64'(line_len_err), 64'd0);
        beat(1'b0, 1'b0, 8'h00);
        send_line(8'h80, 8);
        check_val("len_ok8", 64'(line_len_err), 64'd0);
        send_line(8'h90, 7);
        check_val("len_short7", 64'(line_len_err), 64'd1);
        send_line(8'hA0, 8);
        beat(1'b0, 1'b0, 8'h00);
        check_val("len_sticky", 64'(line_len_err), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
